// File: rtl/rpn_evaluator.sv
// Postfix (RPN) expression evaluator fed token-by-token from an upstream queue.
// Optional signed iterative divider is built when RPN_EVAL_DIV_EN is defined.
module rpn_evaluator #(
  parameter int DATA_W      = 16,
  parameter int STACK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        q_token,
  output logic              q_rd_en,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [1:0]        error
);

  localparam int PW = $clog2(STACK_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] FULL = CW'(STACK_DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] TWO  = CW'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_DIV,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        tok_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [1:0]        err_q, err_d;
  logic [DATA_W-1:0] stk_q [STACK_DEPTH];

  logic              push_en;
  logic [PW-1:0]     push_idx;
  logic [DATA_W-1:0] push_val;

  logic [PW-1:0]     idx_b;
  logic [PW-1:0]     idx_a;
  logic [DATA_W-1:0] top_b;
  logic [DATA_W-1:0] nxt_a;
  logic [DATA_W-1:0] alu;

  logic is_dig;
  logic is_arith;
  logic is_div;
  logic is_eq;
  logic is_clr;

  // Operand b is the top entry, a the one beneath it.
  assign idx_b = PW'(cnt_q - ONE);
  assign idx_a = PW'(cnt_q - TWO);
  assign top_b = stk_q[idx_b];
  assign nxt_a = stk_q[idx_a];

  assign is_dig   = (tok_q <= 4'd9);
  assign is_arith = (tok_q == 4'hA) || (tok_q == 4'hB) || (tok_q == 4'hC);
  assign is_div   = (tok_q == 4'hD);
  assign is_eq    = (tok_q == 4'hE);
  assign is_clr   = (tok_q == 4'hF);

  // Wrapping add / sub / low half of multiply.
  always_comb begin
    alu = '0;
    unique case (1'b1)
      (tok_q == 4'hA): alu = nxt_a + top_b;
      (tok_q == 4'hB): alu = nxt_a - top_b;
      (tok_q == 4'hC): alu = nxt_a * top_b;
      default:         alu = '0;
    endcase
  end

`ifdef RPN_EVAL_DIV_EN
  localparam int YW = $clog2(DATA_W + 1);

  logic              div_load;
  logic [DATA_W-1:0] dv_rem_q;
  logic [DATA_W-1:0] dv_quo_q;
  logic [DATA_W-1:0] dv_dvs_q;
  logic              dv_neg_q;
  logic [YW-1:0]     dv_cyc_q;

  logic [DATA_W-1:0] abs_a;
  logic [DATA_W-1:0] abs_b;
  logic [DATA_W:0]   dv_shl;
  logic [DATA_W:0]   dv_sub;
  logic              dv_ge;
  logic [DATA_W-1:0] dv_rem_nx;
  logic [DATA_W-1:0] dv_quo_nx;
  logic [DATA_W-1:0] dv_quot;
  logic              dv_last;

  // Restoring division on magnitudes; sign fixed up on the last step.
  assign abs_a     = nxt_a[DATA_W-1] ? -nxt_a : nxt_a;
  assign abs_b     = top_b[DATA_W-1] ? -top_b : top_b;
  assign dv_shl    = {dv_rem_q, dv_quo_q[DATA_W-1]};
  assign dv_sub    = dv_shl - {1'b0, dv_dvs_q};
  assign dv_ge     = (dv_shl >= {1'b0, dv_dvs_q});
  assign dv_rem_nx = dv_ge ? dv_sub[DATA_W-1:0] : dv_shl[DATA_W-1:0];
  assign dv_quo_nx = {dv_quo_q[DATA_W-2:0], dv_ge};
  assign dv_quot   = dv_neg_q ? -dv_quo_nx : dv_quo_nx;
  assign dv_last   = (dv_cyc_q == YW'(DATA_W - 1));

  // Divider datapath: load on D, one quotient bit per DIV cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_rem_q <= '0;
      dv_quo_q <= '0;
      dv_dvs_q <= '0;
      dv_neg_q <= 1'b0;
      dv_cyc_q <= '0;
    end else if (div_load) begin
      dv_rem_q <= '0;
      dv_quo_q <= abs_a;
      dv_dvs_q <= abs_b;
      dv_neg_q <= nxt_a[DATA_W-1] ^ top_b[DATA_W-1];
      dv_cyc_q <= '0;
    end else if (state_q == S_DIV) begin
      dv_rem_q <= dv_rem_nx;
      dv_quo_q <= dv_quo_nx;
      dv_cyc_q <= dv_cyc_q + YW'(1);
    end
  end
`endif

  // Next-state, stack update and error/result decisions.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    err_d    = err_q;
    push_en  = 1'b0;
    push_idx = cnt_q[PW-1:0];
    push_val = '0;
`ifdef RPN_EVAL_DIV_EN
    div_load = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d   = 2'd0;
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        unique case (1'b1)
          is_dig: begin
            if (cnt_q == FULL) begin
              err_d   = 2'd2;
              state_d = S_ERR;
            end else begin
              push_en  = 1'b1;
              push_val = DATA_W'(tok_q);
              cnt_d    = cnt_q + ONE;
              state_d  = S_FETCH;
            end
          end
          is_arith: begin
            if (cnt_q < TWO) begin
              err_d   = 2'd1;
              state_d = S_ERR;
            end else begin
              push_en  = 1'b1;
              push_idx = idx_a;
              push_val = alu;
              cnt_d    = cnt_q - ONE;
              state_d  = S_FETCH;
            end
          end
          is_div: begin
            if (cnt_q < TWO) begin
              err_d   = 2'd1;
              state_d = S_ERR;
`ifdef RPN_EVAL_DIV_EN
            end else if (top_b == '0) begin
              err_d   = 2'd3;
              state_d = S_ERR;
            end else begin
              div_load = 1'b1;
              cnt_d    = cnt_q - TWO;
              state_d  = S_DIV;
            end
`else
            end else begin
              err_d   = 2'd3;
              state_d = S_ERR;
            end
`endif
          end
          is_eq: begin
            if (cnt_q == ONE) begin
              res_d   = top_b;
              state_d = S_DONE;
            end else begin
              err_d   = 2'd1;
              state_d = S_ERR;
            end
          end
          is_clr: begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end
          default: begin
            state_d = S_IDLE;
          end
        endcase
      end
`ifdef RPN_EVAL_DIV_EN
      S_DIV: begin
        if (dv_last) begin
          push_en  = 1'b1;
          push_val = dv_quot;
          cnt_d    = cnt_q + ONE;
          state_d  = S_FETCH;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state, stack count, result and error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // Token is captured in the same cycle it is popped from the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok_q <= 4'd0;
    end else if (state_q == S_FETCH) begin
      tok_q <= q_token;
    end
  end

  // Operand stack storage; the count register decides what is live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stk_q[i] <= '0;
      end
    end else if (push_en) begin
      stk_q[push_idx] <= push_val;
    end
  end

  assign q_rd_en = (state_q == S_FETCH);
  assign busy    = (state_q == S_FETCH) || (state_q == S_EXEC) ||
                   (state_q == S_DIV);
  assign done    = (state_q == S_DONE);
  assign result  = res_q;
  assign error   = err_q;

endmodule

// File: tb/tb_rpn_evaluator.sv
// Randomised + directed bench for rpn_evaluator against a queue-based model.
// Division cases follow RPN_EVAL_DIV_EN the same way the design does.
module tb_rpn_evaluator;

  localparam int DW = 16;
  localparam int SD = 8;
`ifdef RPN_EVAL_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    q_token;
  logic          q_rd_en;
  logic          busy;
  logic          done;
  logic [DW-1:0] result;
  logic [1:0]    error;

  logic [3:0]    qmem [0:63];
  int            qlen = 0;
  int            rd_tot = 0;
  int            rd_base = 0;
  int            done_tot = 0;
  int            b2b = 0;
  int            idle_rd = 0;
  logic          prev_rd = 1'b0;
  int            qk;

  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] m_result = '0;

  rpn_evaluator #(
    .DATA_W(DW),
    .STACK_DEPTH(SD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .q_token(q_token),
    .q_rd_en(q_rd_en),
    .busy(busy),
    .done(done),
    .result(result),
    .error(error)
  );

  always #5 clk = ~clk;

  assign qk = rd_tot - rd_base;
  assign q_token = (qk >= 0 && qk < qlen) ? qmem[qk[5:0]] : 4'hE;

  always @(posedge clk) begin
    if (q_rd_en) rd_tot <= rd_tot + 1;
    if (done) done_tot <= done_tot + 1;
    if (q_rd_en && prev_rd) b2b <= b2b + 1;
    if (q_rd_en && !busy) idle_rd <= idle_rd + 1;
    prev_rd <= q_rd_en;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input string s);
    logic [7:0] c;
    qlen = s.len();
    for (int i = 0; i < qlen; i++) begin
      c = s[i];
      if (c >= 8'h30 && c <= 8'h39) qmem[i] = 4'(c - 8'h30);
      else if (c >= 8'h61) qmem[i] = 4'(c - 8'h57);
      else qmem[i] = 4'(c - 8'h37);
    end
  endtask

  // kind: 0 done, 1 error, 2 cleared, 3 ran off the end
  function automatic void model(output int kind, output int err,
                                output int n, output int ndiv,
                                output logic [DW-1:0] res);
    logic [DW-1:0] st[$];
    logic [DW-1:0] a, b, r;
    logic [3:0] t;
    int ai, bi, qi;
    kind = 3; err = 0; n = 0; ndiv = 0; res = m_result;
    for (int i = 0; i < qlen; i++) begin
      t = qmem[i];
      n = i + 1;
      if (t <= 4'd9) begin
        if (st.size() == SD) begin kind = 1; err = 2; return; end
        st.push_back(DW'(t));
      end else if (t == 4'hE) begin
        if (st.size() == 1) begin kind = 0; res = st[0]; end
        else begin kind = 1; err = 1; end
        return;
      end else if (t == 4'hF) begin
        kind = 2;
        return;
      end else begin
        if (st.size() < 2) begin kind = 1; err = 1; return; end
        b = st.pop_back();
        a = st.pop_back();
        r = '0;
        if (t == 4'hA) r = a + b;
        else if (t == 4'hB) r = a - b;
        else if (t == 4'hC) r = a * b;
        else begin
          if (!DIV_EN || b == '0) begin kind = 1; err = 3; return; end
          ai = int'($signed(a));
          bi = int'($signed(b));
          qi = ai / bi;
          r = DW'(qi);
          ndiv++;
        end
        st.push_back(r);
      end
    end
  endfunction

  task automatic run(input string tag, input string s, input bit poke);
    int kind, err, n, ndiv, cyc, d0, b0, i0;
    logic [DW-1:0] res;
    load(s);
    model(kind, err, n, ndiv, res);
    @(negedge clk);
    rd_base = rd_tot;
    d0 = done_tot;
    b0 = b2b;
    i0 = idle_rd;
    start = 1'b1;
    cyc = 1;
    while (1) begin
      @(posedge clk);
      #1;
      cyc++;
      start = poke && (cyc == 6);
      if (!busy || cyc > 600) break;
    end
    start = 1'b0;
    check({tag, ":cycles"}, cyc, 2 * n + 2 + DW * ndiv);
    if (kind == 0) begin
      check({tag, ":done"}, done, 1);
      check({tag, ":result"}, result, res);
      check({tag, ":error"}, error, 0);
    end else begin
      check({tag, ":nodone"}, done, 0);
      check({tag, ":error"}, error, err);
      check({tag, ":held"}, result, res);
    end
    @(posedge clk);
    #1;
    check({tag, ":idle"}, {busy, done}, 0);
    check({tag, ":pulses"}, rd_tot - rd_base, n);
    check({tag, ":ndone"}, done_tot - d0, (kind == 0) ? 1 : 0);
    check({tag, ":rdrule"}, (b2b - b0) + (idle_rd - i0), 0);
    if (kind == 0) m_result = res;
  endtask

  task automatic gen(output string s);
    int d, len, r;
    logic [3:0] t;
    s = "";
    d = 0;
    len = $urandom_range(3, 14);
    for (int k = 0; k < len; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        t = 4'($urandom_range(10, 12));
        if (d > 0) d--;
      end else if (d >= 2 && r < 5) begin
        t = 4'($urandom_range(10, DIV_EN ? 13 : 12));
        d--;
      end else begin
        t = 4'($urandom_range(0, 9));
        d++;
      end
      s = $sformatf("%s%1h", s, t);
    end
    s = {s, "E"};
  endtask

  initial begin
    string s;
    repeat (2) @(posedge clk);
    #1;
    check("rst:busy", busy, 0);
    check("rst:done", done, 0);
    check("rst:rd", q_rd_en, 0);
    check("rst:result", result, 0);
    check("rst:error", error, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run("mul_add", "342CAE", 1'b0);
    check("mul_add:lit", result, 16'd11);
    run("sub", "27BE", 1'b0);
    check("sub:lit", result, 16'hFFFB);
`ifdef RPN_EVAL_DIV_EN
    run("divneg", "05B2DE", 1'b0);
    check("divneg:lit", result, 16'hFFFE);
`else
    run("nodiv", "92DE", 1'b0);
    check("nodiv:lit", error, 2'd3);
`endif
    run("div0", "90DE", 1'b0);
    check("div0:lit", error, 2'd3);
    run("under", "3AE", 1'b0);
    check("under:lit", error, 2'd1);
    run("eq2", "12E", 1'b0);
    check("eq2:lit", error, 2'd1);
    run("over", "123456789E", 1'b0);
    check("over:lit", error, 2'd2);
    run("clear", "5F", 1'b0);
    check("clear:lit", error, 2'd0);
    run("poke", "342CAE", 1'b1);
    check("poke:lit", result, 16'd11);

    for (int i = 0; i < 40; i++) begin
      gen(s);
      run($sformatf("rnd%0d", i), s, 1'b0);
    end

    run("pre_rst", "342CAE", 1'b0);
    load("999CC7DE");
    @(negedge clk);
    rd_base = rd_tot;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (18) @(posedge clk);
    #3;
    check("rst_mid:busy_before", busy, DIV_EN ? 1 : 0);
    rst_n = 1'b0;
    #1;
    check("rst_mid:busy", busy, 0);
    check("rst_mid:done", done, 0);
    check("rst_mid:rd", q_rd_en, 0);
    check("rst_mid:result", result, 0);
    check("rst_mid:error", error, 0);
    m_result = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run("after_rst", "82DE", 1'b0);
`ifdef RPN_EVAL_DIV_EN
    check("after_rst:lit", result, 16'd4);
`else
    check("after_rst:lit", error, 2'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rpn_evaluator.md
RPN_EVALUATOR -- requirements
Module: rpn_evaluator

Interface
REQ-001 Parameter DATA_W, default 16: operand/result width in bits, two's complement.
REQ-002 Parameter STACK_DEPTH, default 8: operand stack entries, power of two, minimum 4.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse that begins evaluating a postfix expression.
REQ-006 q_token  input  4  current postfix token from the upstream shunting-yard output queue.
- Tokens: 0-9 digit, A add, B sub, C mul, D div, E equals, F clear.
REQ-007 q_rd_en  output  1  one-cycle pulse that advances the upstream read index.
REQ-008 busy  output  1  high from the cycle after an accepted start until done or error.
REQ-009 done  output  1  one-cycle pulse when result is valid.
REQ-010 result  output  DATA_W  last valid result, held until the next done.
REQ-011 error  output  2  error code, held until the next accepted start.
- 0 none, 1 stack underflow/bad '=', 2 stack overflow, 3 divide by zero or unsupported op.

Function
REQ-012 States: IDLE, FETCH, EXEC, DIV, DONE, ERR.
REQ-013 IDLE: start moves to FETCH, clears error and the stack count; start while busy is ignored.
REQ-014 FETCH: samples q_token combinationally, registers it, pulses q_rd_en in the same cycle, and moves to EXEC.
REQ-015 EXEC, digit: pushes the digit zero-extended to DATA_W, then returns to FETCH.
REQ-016 EXEC, A/B/C: pops b (top) and a (next), pushes the result, then returns to FETCH.
- A pushes a+b; B pushes a-b; C pushes the low DATA_W bits of a*b.
- All three wrap modulo 2^DATA_W.
REQ-017 EXEC, D: pops b and a and starts the iterative divider in DIV.
- Quotient is signed, truncated toward zero.
- DIV takes exactly DATA_W cycles, then pushes the quotient and returns to FETCH.
REQ-018 EXEC, E:
- Stack count exactly 1: loads result with the top entry and moves to DONE.
- Otherwise: error=1 and moves to ERR.
REQ-019 DONE: pulses done for one cycle, then moves to IDLE.
REQ-020 ERR: holds error, returns to IDLE after one cycle, leaves result unchanged and does not pulse done.
REQ-021 Operator with stack count below 2: error=1, moves to ERR.
REQ-022 Digit push with the stack full (count == STACK_DEPTH): error=2, moves to ERR.
REQ-023 D with b == 0: error=3, moves to ERR; the divider is not started.
REQ-024 Token F, in EXEC or in any state while sampled: aborts to IDLE with no error and no done, and clears the stack count.
REQ-025 Fetch handshake: at most one q_rd_en pulse per token, never two in consecutive cycles, and no pulse in IDLE, DIV, DONE or ERR.
REQ-026 Minimum latency, start to done, for an expression of N tokens with no divisions: 2N+2 cycles.

Reset
REQ-027 rst_n low immediately forces, without waiting for clk:
- state = IDLE, stack count = 0, divider cleared;
- busy = 0, done = 0, q_rd_en = 0, result = 0, error = 0.
REQ-028 Reset mid-evaluation or mid-division discards all partial state; after rst_n deasserts, the block accepts a fresh start.

Configuration
REQ-029 Macro RPN_EVAL_DIV_EN.
- Defined: DIV state and the divider are built, and D behaves per REQ-017 and REQ-023.
- Undefined: no divider logic is built, and token D in EXEC sets error=3 and moves to ERR.

Verification
REQ-030 Queue "3 4 2 C A E" -> done after 14 cycles, result=16'd11, error=0, exactly 6 q_rd_en pulses.
REQ-031 Queue "2 7 B E" -> result=16'hFFFB (-5); then queue "0 5 B 2 D E" with RPN_EVAL_DIV_EN -> result=16'hFFFE (-2, truncated toward zero).
REQ-032 Queue "9 0 D E" -> error=3, no done, result keeps its previous value; without RPN_EVAL_DIV_EN, "9 2 D E" -> error=3.
REQ-033 Queue "3 A E" -> error=1; queue "1 2 E" -> error=1; nine digits with STACK_DEPTH=8 -> error=2 on the ninth digit.
REQ-034 Assert rst_n low during DIV of "9 9 9 C C 7 D E" -> outputs are zero asynchronously; a following "8 2 D E" -> result=16'd4.
REQ-035 Queue "5 F" -> returns to IDLE with no done and error=0; start asserted while busy -> no effect on the running evaluation.
